// File: rtl/gaussian_nb_sdiv_36s_20s_16_seq_if.sv
`default_nettype none
// ============================================================================
// Module  : gaussian_nb_sdiv_36s_20s_16_seq_if
// Purpose : Handshake and operand/result bundle for the 36s/20s signed divider.
// Revision: 1.0 - initial release
// ============================================================================
interface gaussian_nb_sdiv_36s_20s_16_seq_if;
    logic        ce;
    logic        start;
    logic [35:0] din0;
    logic [19:0] din1;
    logic        ready;
    logic        done;
    logic [15:0] dout;
    logic [19:0] rem;
    logic        dbz;
    logic        ovf;

    modport master (
        output ce, start, din0, din1,
        input  ready, done, dout, rem, dbz, ovf
    );

    modport slave (
        input  ce, start, din0, din1,
        output ready, done, dout, rem, dbz, ovf
    );
endinterface
`default_nettype wire

// File: rtl/gaussian_nb_sdiv_36s_20s_16_seq.sv
`default_nettype none
// ============================================================================
// Module  : gaussian_nb_sdiv_36s_20s_16_seq
// Purpose : Sequential signed divider, 36-bit dividend / 20-bit divisor,
//           16-bit quotient, 38-cycle fixed latency (restoring, MSB first).
//           Macro GAUSSIAN_NB_SDIV_SAT_EN: saturate dout on quotient overflow.
// Revision: 1.0 - initial release
// ============================================================================
module gaussian_nb_sdiv_36s_20s_16_seq #(
    parameter logic [31:0] ID         = 32'd1,
    parameter logic [31:0] NUM_STAGE  = 32'd38,
    parameter logic [31:0] din0_WIDTH = 32'd36,
    parameter logic [31:0] din1_WIDTH = 32'd20,
    parameter logic [31:0] dout_WIDTH = 32'd16,
    parameter logic [31:0] rem_WIDTH  = 32'd20
) (
    input  wire logic                        clk,
    input  wire logic                        reset,
    gaussian_nb_sdiv_36s_20s_16_seq_if.slave bus
);

    localparam logic [5:0]  c_ITER_LAST = 6'd35;
    localparam logic [35:0] c_POS_MAX   = 36'd32767;
    localparam logic [35:0] c_NEG_MAX   = 36'd32768;
    localparam logic [15:0] c_DOUT_POS  = 16'h7FFF;
    localparam logic [15:0] c_DOUT_NEG  = 16'h8000;

    generate
        if (din0_WIDTH != 32'd36 || din1_WIDTH != 32'd20 || dout_WIDTH != 32'd16 ||
            rem_WIDTH != 32'd20 || NUM_STAGE != 32'd38) begin : g_bad_config
            $error("gaussian_nb_sdiv_36s_20s_16_seq: unsupported configuration");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic        w_accept;
    logic        w_finish;

    logic [5:0]  r_cnt;
    logic [35:0] r_quo;        // holds dividend magnitude, shifts into quotient
    logic [19:0] r_prem;       // partial remainder, always below the divisor
    logic [19:0] r_div;
    logic        r_neg_q;
    logic        r_neg_r;
    logic        r_op_dbz;

    logic [15:0] r_dout;
    logic [19:0] r_rem;
    logic        r_dbz;
    logic        r_ovf;
    logic        r_done;

    logic [35:0] w_abs0;
    logic [19:0] w_abs1;
    logic [20:0] w_shift;
    logic        w_qbit;
    logic [19:0] w_diff;
    logic [19:0] w_prem_next;

    logic [15:0] w_q16;
    logic [19:0] w_rem_signed;
    logic        w_ovf;
    logic [15:0] w_dout_fix;
    logic [19:0] w_rem_fix;

    // ------------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else if (bus.ce) begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_finish     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.ce && bus.start) begin
                    w_accept     = 1'b1;
                    w_state_next = S_CALC;
                end
            end
            S_CALC: begin
                if (bus.ce && (r_cnt == c_ITER_LAST)) begin
                    w_state_next = S_FIX;
                end
            end
            S_FIX: begin
                if (bus.ce) begin
                    w_finish     = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Operand conditioning and one restoring iteration
    // ------------------------------------------------------------------------
    always_comb begin
        w_abs0 = bus.din0[35] ? (36'd0 - bus.din0) : bus.din0;
        w_abs1 = bus.din1[19] ? (20'd0 - bus.din1) : bus.din1;
    end

    // The true difference is below 2^20 whenever it is taken, so a 20-bit
    // subtraction is exact; bit 20 of the shifted value forces the subtract.
    always_comb begin
        w_shift     = {r_prem, r_quo[35]};
        w_qbit      = w_shift[20] | (w_shift[19:0] >= r_div);
        w_diff      = w_shift[19:0] - r_div;
        w_prem_next = w_qbit ? w_diff : w_shift[19:0];
    end

    // ------------------------------------------------------------------------
    // Sign restoration, overflow and divide-by-zero resolution
    // ------------------------------------------------------------------------
    always_comb begin
        w_q16        = r_neg_q ? (16'd0 - r_quo[15:0]) : r_quo[15:0];
        w_rem_signed = r_neg_r ? (20'd0 - r_prem) : r_prem;
        w_ovf        = r_neg_q ? (r_quo > c_NEG_MAX) : (r_quo > c_POS_MAX);
        w_dout_fix   = w_q16;
        w_rem_fix    = w_rem_signed;
        if (r_op_dbz) begin
            w_dout_fix = r_neg_r ? c_DOUT_NEG : c_DOUT_POS;
            w_rem_fix  = 20'd0;
        end else if (w_ovf) begin
`ifdef GAUSSIAN_NB_SDIV_SAT_EN
            w_dout_fix = r_neg_q ? c_DOUT_NEG : c_DOUT_POS;
`else
            w_dout_fix = w_q16;
`endif
        end
    end

    // ------------------------------------------------------------------------
    // Datapath and result registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt    <= 6'd0;
            r_quo    <= 36'd0;
            r_prem   <= 20'd0;
            r_div    <= 20'd0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_op_dbz <= 1'b0;
            r_dout   <= 16'd0;
            r_rem    <= 20'd0;
            r_dbz    <= 1'b0;
            r_ovf    <= 1'b0;
            r_done   <= 1'b0;
        end else if (bus.ce) begin
            r_done <= w_finish;
            if (w_accept) begin
                r_cnt    <= 6'd0;
                r_quo    <= w_abs0;
                r_prem   <= 20'd0;
                r_div    <= w_abs1;
                r_neg_q  <= bus.din0[35] ^ bus.din1[19];
                r_neg_r  <= bus.din0[35];
                r_op_dbz <= (bus.din1 == 20'd0);
            end else if (r_state == S_CALC) begin
                r_cnt  <= r_cnt + 6'd1;
                r_quo  <= {r_quo[34:0], w_qbit};
                r_prem <= w_prem_next;
            end
            if (w_finish) begin
                r_dout <= w_dout_fix;
                r_rem  <= w_rem_fix;
                r_dbz  <= r_op_dbz;
                r_ovf  <= w_ovf & ~r_op_dbz;
            end
        end
    end

    // A finished result waiting through ce=0 is presented on the next ce=1 cycle.
    assign bus.ready = (r_state == S_IDLE);
    assign bus.done  = r_done & bus.ce;
    assign bus.dout  = r_dout;
    assign bus.rem   = r_rem;
    assign bus.dbz   = r_dbz;
    assign bus.ovf   = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_gaussian_nb_sdiv_36s_20s_16_seq.sv
`default_nettype none
// ============================================================================
// Module  : tb_gaussian_nb_sdiv_36s_20s_16_seq
// Purpose : Self-checking bench for the 36s/20s sequential signed divider.
// Revision: 1.0 - initial release
// ============================================================================
module tb_gaussian_nb_sdiv_36s_20s_16_seq;

`ifdef GAUSSIAN_NB_SDIV_SAT_EN
    localparam bit c_SAT = 1'b1;
`else
    localparam bit c_SAT = 1'b0;
`endif

    logic clk;
    logic reset;
    int   n_checks;
    int   n_pass;

    gaussian_nb_sdiv_36s_20s_16_seq_if bus ();

    gaussian_nb_sdiv_36s_20s_16_seq dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Reference: plain signed arithmetic on sign-extended operands.
    function automatic void model(input logic [35:0] a, input logic [19:0] b,
                                  output logic [15:0] q, output logic [19:0] r,
                                  output logic z, output logic o);
        longint sa;
        longint sb;
        longint qq;
        longint rr;
        sa = {{28{a[35]}}, a};
        sb = {{44{b[19]}}, b};
        if (sb == 0) begin
            z = 1'b1;
            o = 1'b0;
            r = 20'd0;
            q = (sa < 0) ? 16'h8000 : 16'h7FFF;
        end else begin
            qq = sa / sb;
            rr = sa % sb;
            z  = 1'b0;
            o  = (qq > 32767) || (qq < -32768);
            r  = rr[19:0];
            if (o && c_SAT) q = (qq < 0) ? 16'h8000 : 16'h7FFF;
            else            q = qq[15:0];
        end
    endfunction

    // Entered and left at #1 after a rising edge.
    task automatic do_op(input logic [35:0] a, input logic [19:0] b, input int ce_pct);
        logic [15:0] eq;
        logic [19:0] er;
        logic        ez;
        logic        eo;
        logic [63:0] t;
        int          ce_cnt;
        int          cyc;
        int          done_seen;
        int          done_at;
        int          ready_bad;
        bit          busy;
        model(a, b, eq, er, ez, eo);
        bus.ce    = 1'b1;
        bus.start = 1'b1;
        bus.din0  = a;
        bus.din1  = b;
        #1;
        check("ready_before_start", 64'(bus.ready), 64'd1);
        @(posedge clk); #1;
        bus.start = 1'b0;
        ce_cnt    = 0;
        cyc       = 0;
        done_seen = 0;
        done_at   = -1;
        ready_bad = 0;
        while (ce_cnt < 38 && cyc < 400) begin
            busy   = (ce_cnt < 37);
            bus.ce = (int'($urandom_range(99)) < ce_pct);
            if (ce_cnt < 37) begin
                t         = {$urandom, $urandom};
                bus.din0  = t[35:0];
                bus.din1  = t[55:36];
                bus.start = 1'($urandom_range(1));
            end else begin
                bus.start = 1'b0;
            end
            if (bus.ce) ce_cnt++;
            #1;
            if (bus.done) begin
                done_seen++;
                done_at = ce_cnt;
            end
            if (bus.ready !== !busy) ready_bad++;
            cyc++;
            @(posedge clk); #1;
        end
        bus.ce    = 1'b1;
        bus.start = 1'b0;
        check("ready_during_op", 64'(ready_bad), 64'd0);
        check("done_count", 64'(done_seen), 64'd1);
        check("done_latency", 64'(done_at), 64'd38);
        check("dout", 64'(bus.dout), 64'(eq));
        check("rem", 64'(bus.rem), 64'(er));
        check("dbz", 64'(bus.dbz), 64'(ez));
        check("ovf", 64'(bus.ovf), 64'(eo));
    endtask

    initial begin
        logic [63:0] t;
        logic [35:0] ra;
        logic [19:0] rb;
        int          nd;
        n_checks  = 0;
        n_pass    = 0;
        reset     = 1'b1;
        bus.ce    = 1'b0;
        bus.start = 1'b0;
        bus.din0  = 36'd0;
        bus.din1  = 20'd0;
        repeat (3) @(posedge clk);
        #1;
        reset  = 1'b0;
        bus.ce = 1'b1;
        #1;
        check("rst_ready", 64'(bus.ready), 64'd1);
        check("rst_done",  64'(bus.done),  64'd0);
        check("rst_dout",  64'(bus.dout),  64'd0);
        check("rst_rem",   64'(bus.rem),   64'd0);
        check("rst_dbz",   64'(bus.dbz),   64'd0);
        check("rst_ovf",   64'(bus.ovf),   64'd0);
        @(posedge clk); #1;

        do_op(36'd100, 20'd7, 100);
        do_op(-36'sd100, 20'd7, 100);
        do_op(36'd100, -20'sd7, 100);
        do_op(36'h4_0000_0000, 20'd1, 100);
        do_op(-36'sd5, 20'd0, 100);
        // Outputs hold through idle cycles until the next completion.
        repeat (5) @(posedge clk);
        #1;
        check("hold_dout", 64'(bus.dout), 64'h8000);
        check("hold_dbz",  64'(bus.dbz),  64'd1);
        do_op(36'd5, 20'd0, 100);
        do_op(36'd327670, 20'd10, 100);
        do_op(36'd327680, 20'd10, 100);
        do_op(-36'sd327680, 20'd10, 100);
        do_op(-36'sd327690, 20'd10, 100);
        do_op(36'h8_0000_0000, -20'sd1, 100);
        do_op(36'h8_0000_0000, 20'h8_0000, 100);
        do_op(36'h7_FFFF_FFFF, 20'h8_0000, 100);
        do_op(-36'sd7, 20'd100, 100);
        // ce gaps mid-operation with junk restarts: latency stretches, result holds.
        do_op(36'd1000000, -20'sd3, 75);
        do_op(36'd100, 20'd7, 100);

        // Reset in the middle of CALC abandons the operation, even with ce=0.
        bus.din0  = 36'd123456;
        bus.din1  = 20'd77;
        bus.ce    = 1'b1;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        reset  = 1'b1;
        bus.ce = 1'b0;
        @(posedge clk); #1;
        reset  = 1'b0;
        bus.ce = 1'b1;
        #1;
        check("mid_rst_ready", 64'(bus.ready), 64'd1);
        check("mid_rst_done",  64'(bus.done),  64'd0);
        check("mid_rst_dout",  64'(bus.dout),  64'd0);
        check("mid_rst_rem",   64'(bus.rem),   64'd0);
        check("mid_rst_dbz",   64'(bus.dbz),   64'd0);
        check("mid_rst_ovf",   64'(bus.ovf),   64'd0);
        nd = 0;
        for (int i = 0; i < 45; i++) begin
            @(posedge clk); #1;
            if (bus.done) nd++;
        end
        check("no_done_after_rst", 64'(nd), 64'd0);
        do_op(36'd77777, 20'd123, 100);

        for (int k = 0; k < 30; k++) begin
            t  = {$urandom, $urandom};
            ra = t[35:0];
            ra = 36'($signed(ra) >>> $urandom_range(0, 34));
            rb = t[55:36];
            rb = 20'($signed(rb) >>> $urandom_range(0, 18));
            if ($urandom_range(7) == 0) rb = 20'd0;
            do_op(ra, rb, 70 + int'($urandom_range(30)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
